muldiv_seq: RTL and testbench

Iterative unsigned multiply/divide sequencer for the pipeline's EX stage. It accepts a MULTU or DIVU request, then drives one `alu_file` instance for 32 cycles, one add or subtract per cycle, using shift-add multiply or restoring divide. Results land in architectural HI/LO registers that are held until the next completed operation. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/alu_file_if.sv | 14 +
 rtl/alu_file.sv | 38 +++
 rtl/muldiv_seq.sv | 141 ++++++++++++++
 tb/tb_muldiv_seq.sv | 134 +++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: data word, ALU opcodes, mult/div opcodes
package cpu_types_pkg;

  localparam int WORD_W      = 32;
  localparam int MULDIV_ITER = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9
  } aluop_t;

  typedef enum logic {
    MD_MULTU = 1'b0,
    MD_DIVU  = 1'b1
  } muldiv_op_t;

endpackage

// File: rtl/alu_file_if.sv
// rtl/alu_file_if.sv - connection bundle between an ALU client and alu_file
interface alu_file_if;
  import cpu_types_pkg::*;

  aluop_t aluop;
  word_t  input_a;
  word_t  input_b;
  word_t  out;
  logic   overflow;

  modport master (output aluop, output input_a, output input_b, input out, input overflow);
  modport slave  (input aluop, input input_a, input input_b, output out, output overflow);

endinterface

// File: rtl/alu_file.sv
// rtl/alu_file.sv - combinational integer ALU with signed overflow detect
module alu_file
  import cpu_types_pkg::*;
(
  alu_file_if.slave aif
);

  word_t w_sum;
  word_t w_diff;

  assign w_sum  = aif.input_a + aif.input_b;
  assign w_diff = aif.input_a - aif.input_b;

  always_comb begin
    aif.out      = '0;
    aif.overflow = 1'b0;
    case (aif.aluop)
      ALU_ADD: begin
        aif.out      = w_sum;
        aif.overflow = (aif.input_a[31] == aif.input_b[31]) && (w_sum[31] != aif.input_a[31]);
      end
      ALU_SUB: begin
        aif.out      = w_diff;
        aif.overflow = (aif.input_a[31] != aif.input_b[31]) && (w_diff[31] != aif.input_a[31]);
      end
      ALU_AND:  aif.out = aif.input_a & aif.input_b;
      ALU_OR:   aif.out = aif.input_a | aif.input_b;
      ALU_XOR:  aif.out = aif.input_a ^ aif.input_b;
      ALU_NOR:  aif.out = ~(aif.input_a | aif.input_b);
      ALU_SLT:  aif.out = {31'd0, $signed(aif.input_a) < $signed(aif.input_b)};
      ALU_SLTU: aif.out = {31'd0, aif.input_a < aif.input_b};
      ALU_SLL:  aif.out = aif.input_a << aif.input_b[4:0];
      ALU_SRL:  aif.out = aif.input_a >> aif.input_b[4:0];
      default:  aif.out = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULTU/DIVU sequencer driving one shared ALU
module muldiv_seq
  import cpu_types_pkg::*;
#(
  parameter int ITER = MULDIV_ITER
)
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       start,
  input  muldiv_op_t op,
  input  word_t      a,
  input  word_t      b,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output word_t      hi,
  output word_t      lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam logic [5:0] LP_LAST = 6'(ITER - 1);

  muldiv_state_t r_state;
  word_t         r_acc;
  word_t         r_q;
  word_t         r_opnd;
  logic [5:0]    r_cnt;
  word_t         r_hi;
  word_t         r_lo;
  logic          r_dbz;

  word_t w_r;
  logic  w_s;
  logic  w_c;
  logic  w_ge;
  word_t w_acc_nxt;
  word_t w_q_nxt;

  alu_file_if aluif ();
  alu_file u_alu (.aif(aluif.slave));

  assign w_r  = {r_acc[30:0], r_q[31]};
  assign w_s  = r_acc[31];
  // Unsigned wrap of acc+opnd is the carry out of the add.
  assign w_c  = (aluif.out < r_acc);
  assign w_ge = w_s | (w_r >= r_opnd);

  always_comb begin
    aluif.aluop   = ALU_ADD;
    aluif.input_a = '0;
    aluif.input_b = '0;
    w_acc_nxt     = r_acc;
    w_q_nxt       = r_q;
    case (r_state)
      MUL: begin
        aluif.aluop   = ALU_ADD;
        aluif.input_a = r_acc;
        aluif.input_b = r_opnd;
        if (r_q[0]) {w_acc_nxt, w_q_nxt} = {w_c, aluif.out, r_q[31:1]};
        else        {w_acc_nxt, w_q_nxt} = {1'b0, r_acc, r_q[31:1]};
      end
      DIV: begin
        aluif.aluop   = ALU_SUB;
        aluif.input_a = w_r;
        aluif.input_b = r_opnd;
        w_acc_nxt     = w_ge ? aluif.out : w_r;
        w_q_nxt       = {r_q[30:0], w_ge};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_q     <= '0;
      r_opnd  <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_acc <= '0;
            r_cnt <= '0;
            if (op == MD_MULTU) begin
              r_q     <= b;
              r_opnd  <= a;
              r_state <= MUL;
            end else if (b != '0) begin
              r_q     <= a;
              r_opnd  <= b;
              r_state <= DIV;
            end else begin
              r_hi    <= a;
              r_lo    <= '1;
              r_dbz   <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        MUL, DIV: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 6'd1;
            // Commit the post-iteration values so HI/LO include the final step.
            if (r_cnt == LP_LAST) begin
              r_hi    <= w_acc_nxt;
              r_lo    <= w_q_nxt;
              r_dbz   <= 1'b0;
              r_state <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state == MUL) || (r_state == DIV);
  assign done        = (r_state == DONE);
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       nRST;
  logic       start;
  muldiv_op_t op;
  word_t      a;
  word_t      b;
  logic       flush;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  word_t      hi;
  word_t      lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq #(.ITER(32)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 plain, 1 stray start at cycle inj, 2 flush at cycle inj, 3 async reset at cycle inj
  task automatic run_op(input string tag, input muldiv_op_t op_i, input word_t a_i, input word_t b_i,
                        input word_t eh, input word_t el, input logic edbz, input int elat,
                        input int kind, input int inj);
    int lat;
    int nbusy;
    @(posedge CLK); #1;
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0;
    nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (c == inj + 1) begin
        start = 1'b0;
        flush = 1'b0;
      end
      if (kind == 2 && c == inj + 1) begin
        chk({tag, " busy after flush"}, 64'(busy), 64'd0);
        chk({tag, " done after flush"}, 64'(done), 64'd0);
        break;
      end
      if (busy) nbusy++;
      if (done) begin
        lat = c;
        break;
      end
      if (c == inj) begin
        case (kind)
          1: begin start = 1'b1; op = MD_DIVU; a = 32'd1000; b = 32'd10; end
          2: flush = 1'b1;
          3: begin
            #2 nRST = 1'b0;
            #1;
            chk({tag, " rst busy"}, 64'(busy), 64'd0);
            chk({tag, " rst done"}, 64'(done), 64'd0);
            chk({tag, " rst dbz"},  64'(div_by_zero), 64'd0);
            chk({tag, " rst hi"},   64'(hi), 64'd0);
            chk({tag, " rst lo"},   64'(lo), 64'd0);
            @(posedge CLK); #1;
            nRST = 1'b1;
            return;
          end
          default: ;
        endcase
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    if (kind != 2) begin
      chk({tag, " busy cycles"}, 64'(nbusy), 64'(elat - 1));
    end
    chk({tag, " hi"},  64'(hi), 64'(eh));
    chk({tag, " lo"},  64'(lo), 64'(el));
    chk({tag, " dbz"}, 64'(div_by_zero), 64'(edbz));
  endtask

  initial begin
    nRST  = 1'b0;
    start = 1'b0;
    op    = MD_MULTU;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz",  64'(div_by_zero), 64'd0);
    chk("reset hi",   64'(hi), 64'd0);
    chk("reset lo",   64'(lo), 64'd0);
    #5 nRST = 1'b1;

    run_op("mul 7x6",   MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, 0, 0);
    run_op("mul max",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 0, 0);
    run_op("div 100/7", MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 0, 0);
    run_op("div msb",   MD_DIVU,  32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1, 1'b0, 33, 0, 0);
    run_op("div by 0",  MD_DIVU,  32'd8, 32'd0, 32'd8, 32'hFFFFFFFF, 1'b1, 1, 0, 0);
    run_op("mul stray", MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, 1, 10);
    run_op("div flush", MD_DIVU,  32'd1000, 32'd3, 32'd0, 32'd42, 1'b0, 0, 2, 15);
    run_op("div reset", MD_DIVU,  32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 0, 3, 20);

    @(posedge CLK); #1;
    start = 1'b1; flush = 1'b1; op = MD_MULTU; a = 32'd9; b = 32'd9;
    @(posedge CLK); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge CLK);
    chk("start+flush busy", 64'(busy), 64'd0);
    chk("start+flush done", 64'(done), 64'd0);

    run_op("mul 3x5",   MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
